// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and sizing helpers for the multi-cycle data memory
package dmem_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int DATA_W_DEF = 16;
  localparam int BO         = $clog2(DATA_W_DEF / 8);

  function automatic int byteOffBits(input int dataW);
    return $clog2(dataW / 8);
  endfunction

  // Counter only ever holds LATENCY-1, so LATENCY==1 or 2 still needs one bit.
  function automatic int cntWidth(input int latency);
    return (latency <= 2) ? 1 : $clog2(latency);
  endfunction

endpackage

// File: rtl/dmem_if.sv
// rtl/dmem_if.sv - memory-stage request/response bundle between pipeline and data memory
interface dmem_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              memRead;
  logic              memWrt;
  logic              halt;
  logic [ADDR_W-1:0] aluOut;
  logic [DATA_W-1:0] writeData;
  logic [DATA_W-1:0] readData;
  logic              stall;
  logic              done;
  logic              err;

  modport master (
    output memRead, memWrt, halt, aluOut, writeData,
    input  readData, stall, done, err
  );

  modport slave (
    input  memRead, memWrt, halt, aluOut, writeData,
    output readData, stall, done, err
  );
endinterface

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - word storage with synchronous write and asynchronous read; never cleared
module dmem_array #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/dmem_stall_ctrl.sv
// rtl/dmem_stall_ctrl.sv - multi-cycle data memory with pipeline stall and fixed access latency
// Optional misaligned-request rejection with err pulse: define DMEM_ALIGN_CHK_EN.
module dmem_stall_ctrl
  import dmem_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic   clk,
  input  logic   rst,
  dmem_if.slave  bus
);

  localparam int BOFF  = byteOffBits(DATA_W);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = cntWidth(LATENCY);

  state_t            state, nextState;
  logic [CNT_W-1:0]  cnt, nextCnt;
  logic [IDX_W-1:0]  idxQ;
  logic [DATA_W-1:0] wdataQ;
  logic [DATA_W-1:0] readDataQ;
  logic [DATA_W-1:0] arrRdata;
  logic              isStoreQ;
  logic              req;
  logic              misaligned;
  logic              accept;
  logic              finish;
  logic              we;
  logic              unusedAddr;

  assign req        = (bus.memRead | bus.memWrt) & ~bus.halt;
  assign unusedAddr = ^bus.aluOut;

`ifdef DMEM_ALIGN_CHK_EN
  localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'((1 << BOFF) - 1);
  assign misaligned = |(bus.aluOut & LOW_MASK);
  assign bus.err    = rst & (state == IDLE) & req & misaligned;
`else
  assign misaligned = 1'b0;
  assign bus.err    = 1'b0;
`endif

  always_comb begin
    nextState = state;
    nextCnt   = cnt;
    accept    = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (req && !misaligned) begin
          accept    = 1'b1;
          nextState = BUSY;
          nextCnt   = CNT_W'(LATENCY - 1);
        end
      end
      BUSY: begin
        if (cnt != '0) begin
          nextCnt = cnt - 1'b1;
        end else begin
          finish    = 1'b1;
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // Outputs are masked while reset is asserted so an aborted access never reports or commits.
  assign bus.stall    = rst & (accept | ((state == BUSY) && (cnt != '0)));
  assign bus.done     = rst & finish;
  assign we           = rst & finish & isStoreQ;
  assign bus.readData = (bus.done && !isStoreQ) ? arrRdata : readDataQ;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      readDataQ <= '0;
    end else begin
      state <= nextState;
      cnt   <= nextCnt;
      if (finish && !isStoreQ) readDataQ <= arrRdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && accept) begin
      idxQ     <= bus.aluOut[IDX_W+BOFF-1:BOFF];
      wdataQ   <= bus.writeData;
      isStoreQ <= bus.memWrt;
    end
  end

  dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (we),
    .idx   (idxQ),
    .wdata (wdataQ),
    .rdata (arrRdata)
  );

endmodule
